mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) memory arbiter: IDLE/GNT_I/GNT_D with registered grant.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the data cache always wins.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_i_pend;
    logic   w_d_pend;

`ifdef ARB_ROUND_ROBIN_EN
    logic   r_prefer_i;
    logic   w_prefer_i_nxt;
`endif

    assign w_i_pend = i_read | i_write;
    assign w_d_pend = d_read | d_write;

    // Read data is shared; only the ready strobe identifies the owner.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state    <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            r_prefer_i <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            r_prefer_i <= w_prefer_i_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
`ifdef ARB_ROUND_ROBIN_EN
        w_prefer_i_nxt = r_prefer_i;
`endif
        busy      = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (r_state)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                // On contention the pointer decides; it flips on every grant entry.
                if (w_d_pend && !(w_i_pend && r_prefer_i)) begin
                    w_state_nxt    = GNT_D;
                    w_prefer_i_nxt = 1'b1;
                end else if (w_i_pend) begin
                    w_state_nxt    = GNT_I;
                    w_prefer_i_nxt = 1'b0;
                end
`else
                if (w_d_pend) begin
                    w_state_nxt = GNT_D;
                end else if (w_i_pend) begin
                    w_state_nxt = GNT_I;
                end
`endif
            end
            GNT_I: begin
                busy      = 1'b1;
                mem_read  = i_read;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
                // Completion or requester withdrawal both release the grant.
                if (mem_ready || !w_i_pend) begin
                    w_state_nxt = IDLE;
                end
            end
            GNT_D: begin
                busy      = 1'b1;
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
                if (mem_ready || !w_d_pend) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level ownership model.
module tb_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned VW = 5 + AW + 3 * DW;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_wdata, d_wdata, mem_wdata, mem_rdata, i_rdata, d_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner 0 = nobody, 1 = I-cache, 2 = D-cache; last_grant 0 after reset.
    int owner;
    int last_grant;
    logic [VW-1:0] exp_vec, obs_vec;
    int   dut_log[$];
    logic prev_busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    // Wait to the falling edge and form expected/observed output vectors.
    task automatic sample();
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        if (proc_reset) begin
            owner = 0; last_grant = 0;
        end
        e_rd   = (owner == 1) ? i_read  : (owner == 2) ? d_read  : 1'b0;
        e_wr   = (owner == 1) ? i_write : (owner == 2) ? d_write : 1'b0;
        e_addr = (owner == 1) ? i_addr  : (owner == 2) ? d_addr  : '0;
        e_wd   = (owner == 1) ? i_wdata : (owner == 2) ? d_wdata : '0;
        exp_vec = {(owner != 0), e_rd, e_wr, e_addr, e_wd,
                   ((owner == 1) && mem_ready), ((owner == 2) && mem_ready),
                   mem_rdata, mem_rdata};
        obs_vec = {busy, mem_read, mem_write, mem_addr, mem_wdata,
                   i_ready, d_ready, i_rdata, d_rdata};
        if (busy === 1'b1 && prev_busy !== 1'b1)
            dut_log.push_back((mem_addr === d_addr) ? 2 : 1);
        prev_busy = busy;
    endtask

    // Advance the ownership model across one rising edge.
    task automatic tick();
        bit ip, dp;
        @(posedge clk);
        ip = i_read || i_write;
        dp = d_read || d_write;
        if (proc_reset) begin
            owner = 0; last_grant = 0;
        end else if (owner == 0) begin
            if (ip && dp)  owner = (RR && last_grant == 2) ? 1 : 2;
            else if (dp)   owner = 2;
            else if (ip)   owner = 1;
            if (owner != 0) last_grant = owner;
        end else if (mem_ready || !((owner == 1) ? ip : dp)) begin
            owner = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        proc_reset = 1;
        idle_inputs();
        owner = 0; last_grant = 0;
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 0;
        prev_busy = 0;
        dut_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        proc_reset = 1;
        i_read = 1; d_write = 1; mem_ready = 1;
        i_addr = AW'($urandom); d_addr = AW'($urandom);
        for (int k = 0; k < 3; k++) begin
            mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL reset cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            tick();
        end
        idle_inputs();
        proc_reset = 0;
    endtask

    task automatic test_single_i_read();
        int n_ir, n_dr;
        do_reset();
        n_ir = 0; n_dr = 0;
        i_addr = 28'h0000010; d_addr = 28'h0000020; i_wdata = rnd_data();
        for (int k = 0; k < 6; k++) begin
            i_read = (k < 4); mem_ready = (k == 3); mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL single_i_read cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (i_ready === 1'b1) n_ir++;
            if (d_ready === 1'b1) n_dr++;
            tick();
        end
        n_checks++;
        if (n_ir != 1 || n_dr != 0) begin
            n_errors++;
            $display("FAIL single_i_read pulses: got i_ready=%0d d_ready=%0d expected 1 0", n_ir, n_dr);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] ones;
        int g0, g1;
        ones = {32{4'h1}};
        do_reset();
        i_addr = 28'h0000123; d_addr = 28'h0ABCDEF; d_wdata = ones;
        for (int k = 0; k < 8; k++) begin
            i_read = (k < 6); d_write = (k < 3);
            mem_ready = (k == 2) || (k == 5); mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL simultaneous cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (k == 1) begin
                n_checks++;
                if (mem_write !== 1'b1 || mem_wdata !== ones || mem_addr !== 28'h0ABCDEF) begin
                    n_errors++;
                    $display("FAIL simultaneous dwrite: got wr=%b addr=%h wdata=%h expected 1 0abcdef %h",
                             mem_write, mem_addr, mem_wdata, ones);
                end
            end
            tick();
        end
        g0 = (dut_log.size() > 0) ? dut_log[0] : 0;
        g1 = (dut_log.size() > 1) ? dut_log[1] : 0;
        n_checks++;
        if (g0 != 2 || g1 != 1) begin
            n_errors++;
            $display("FAIL simultaneous order: got %0d,%0d expected 2,1", g0, g1);
        end
        idle_inputs();
    endtask

    task automatic test_continuous();
        int exp_o[3];
        int got;
        if (RR) exp_o = '{2, 1, 2}; else exp_o = '{2, 2, 2};
        do_reset();
        i_addr = 28'h0000AAA; d_addr = 28'h0000BBB;
        for (int k = 0; k < 6; k++) begin
            i_read = 1; d_read = 1; mem_ready = 1; mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL continuous cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < dut_log.size()) ? dut_log[i] : 0;
            n_checks++;
            if (got != exp_o[i]) begin
                n_errors++;
                $display("FAIL continuous grant%0d: got %0d expected %0d", i, got, exp_o[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_writeback_then_read();
        int exp_o[3];
        int got;
        if (RR) exp_o = '{2, 1, 2}; else exp_o = '{2, 2, 2};
        do_reset();
        i_addr = 28'h0000C00; d_addr = 28'h0000D00; d_wdata = rnd_data(); i_wdata = rnd_data();
        for (int k = 0; k < 7; k++) begin
            d_write = (k < 2); d_read = (k >= 2); i_read = (k < 4);
            mem_ready = 1; mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL writeback cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < dut_log.size()) ? dut_log[i] : 0;
            n_checks++;
            if (got != exp_o[i]) begin
                n_errors++;
                $display("FAIL writeback grant%0d: got %0d expected %0d", i, got, exp_o[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_grant();
        logic [VW-1:0] zero_obs;
        int got;
        do_reset();
        i_addr = 28'h0000111; d_addr = 28'h0000222; d_read = 1;
        for (int k = 0; k < 2; k++) begin
            mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL reset_mid cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (k == 0) tick();
        end
        // Mid-cycle asynchronous reset while D holds the grant.
        proc_reset = 1; mem_ready = 1;
        #1;
        zero_obs = {busy, mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready, {2*DW{1'b0}}};
        n_checks++;
        if (zero_obs !== '0) begin
            n_errors++;
            $display("FAIL reset_mid async: got %h expected all zero", zero_obs);
        end
        owner = 0; last_grant = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin proc_reset = 0; d_read = 0; end
            mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec || d_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid late_ready cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            tick();
        end
        dut_log.delete();
        for (int k = 0; k < 2; k++) begin
            i_read = 1; d_read = 1; mem_ready = 1; mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL reset_mid regrant cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            tick();
        end
        got = (dut_log.size() > 0) ? dut_log[0] : 0;
        n_checks++;
        if (got != 2) begin
            n_errors++;
            $display("FAIL reset_mid pointer: got grant %0d expected 2", got);
        end
        idle_inputs();
    endtask

    task automatic test_drop();
        do_reset();
        i_addr = 28'h0000333; d_addr = 28'h0000444;
        for (int k = 0; k < 5; k++) begin
            i_read = (k < 2); mem_ready = (k >= 3); mem_rdata = rnd_data();
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL drop cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (k >= 3) begin
                n_checks++;
                if (i_ready !== 1'b0 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL drop late_ready cyc%0d: got i_ready=%b busy=%b expected 0 0", k, i_ready, busy);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            proc_reset = ($urandom_range(0, 96) == 0);
            i_read  = ($urandom_range(0, 3) != 0);
            i_write = ($urandom_range(0, 3) == 0);
            d_read  = ($urandom_range(0, 2) == 0);
            d_write = ($urandom_range(0, 2) == 0);
            i_addr = AW'($urandom); d_addr = AW'($urandom);
            i_wdata = rnd_data(); d_wdata = rnd_data(); mem_rdata = rnd_data();
            mem_ready = ($urandom_range(0, 99) < 35);
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL random cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            tick();
        end
        proc_reset = 0;
        idle_inputs();
    endtask

    initial begin
        proc_reset = 1;
        idle_inputs();
        test_reset();
        test_single_i_read();
        test_simultaneous();
        test_continuous();
        test_writeback_then_read();
        test_reset_mid_grant();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
